// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared state encoding and default widths for the pipeline sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int c_reg_aw = 3;
  localparam int c_cnt_w  = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_dff.sv
// ============================================================================
// Module  : hazard_ctrl_dff
// Brief   : Generic W-bit register with asynchronous active-low clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_raw_detect.sv
// ============================================================================
// Module  : raw_detect
// Brief   : Combinational RAW comparator of ID sources against EX and MEM writers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module raw_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = c_reg_aw
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_vld,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_vld,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_regwrite,
  output logic              raw_ex,
  output logic              raw_mem
);

  assign raw_ex  = ex_regwrite  & ((id_rs_vld & (id_rs == ex_wreg)) |
                                   (id_rt_vld & (id_rt == ex_wreg)));
  assign raw_mem = mem_regwrite & ((id_rs_vld & (id_rs == mem_wreg)) |
                                   (id_rt_vld & (id_rt == mem_wreg)));

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : 5-stage pipeline sequencer: RAW stalls, EX redirects, dmem waits, halt.
//           FORWARD_EN: when defined only load-use hazards stall ID.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W  = c_cnt_w,
  parameter int REG_AW = c_reg_aw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_vld,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_vld,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_regwrite,
  input  logic              ex_redirect,
  input  logic              dmem_stall,
  input  logic              dmem_done,
  input  logic              wb_halt,
  output logic              pc_hold,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              freeze,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             w_raw_ex;
  logic             w_raw_mem;
  logic             w_hazard;
  logic             w_unused_sink;
  logic [1:0]       r_state_q;
  state_t           r_state;
  state_t           w_state_d;
  logic             r_pend;
  logic             w_pend_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  raw_detect #(.REG_AW(REG_AW)) u_raw_detect (
    .id_rs        (id_rs),
    .id_rs_vld    (id_rs_vld),
    .id_rt        (id_rt),
    .id_rt_vld    (id_rt_vld),
    .ex_wreg      (ex_wreg),
    .ex_regwrite  (ex_regwrite),
    .mem_wreg     (mem_wreg),
    .mem_regwrite (mem_regwrite),
    .raw_ex       (w_raw_ex),
    .raw_mem      (w_raw_mem)
  );

`ifdef FORWARD_EN
  assign w_hazard      = w_raw_ex & ex_memread;
  assign w_unused_sink = w_raw_mem;
`else
  assign w_hazard      = w_raw_ex | w_raw_mem;
  assign w_unused_sink = ex_memread;
`endif

  hazard_ctrl_dff #(.W(2)) u_state_reg (
    .clk(clk), .rst_n(rst_n), .d(w_state_d), .q(r_state_q)
  );
  assign r_state = state_t'(r_state_q);

  hazard_ctrl_dff #(.W(1)) u_pend_reg (
    .clk(clk), .rst_n(rst_n), .d(w_pend_d), .q(r_pend)
  );

  // Outputs are gated by rst_n so an asserted reset silences them without a clock.
  always_comb begin
    pc_hold      = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    freeze       = 1'b0;
    halted       = 1'b0;
    w_state_d    = r_state;
    w_pend_d     = r_pend;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (wb_halt) begin
            freeze    = 1'b1;
            w_state_d = ST_HALT;
          end else if (dmem_stall && !dmem_done) begin
            freeze    = 1'b1;
            w_state_d = ST_MWAIT;
            w_pend_d  = ex_redirect;
          end else if (ex_redirect || r_pend) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_pend_d    = 1'b0;
          end else if (w_hazard) begin
            pc_hold      = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MWAIT: begin
          // WB is frozen here, so a halt in WB is picked up again once back in RUN.
          w_pend_d = r_pend | ex_redirect;
          if (dmem_done) w_state_d = ST_RUN;
          else           freeze    = 1'b1;
        end
        ST_HALT: begin
          freeze  = 1'b1;
          pc_hold = 1'b1;
          halted  = 1'b1;
        end
        default: w_state_d = ST_RUN;
      endcase
    end
  end

  assign w_cnt_d = ((pc_hold | freeze) & ~halted & (r_cnt != {CNT_W{1'b1}}))
                 ? r_cnt + CNT_W'(1) : r_cnt;

  hazard_ctrl_dff #(.W(CNT_W)) u_cnt_reg (
    .clk(clk), .rst_n(rst_n), .d(w_cnt_d), .q(r_cnt)
  );
  assign stall_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed self-checking bench for hazard_ctrl (honours FORWARD_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  id_rs = '0, id_rt = '0, ex_wreg = '0, mem_wreg = '0;
  logic        id_rs_vld = 0, id_rt_vld = 0, ex_regwrite = 0, ex_memread = 0;
  logic        mem_regwrite = 0, ex_redirect = 0, dmem_stall = 0, dmem_done = 0;
  logic        wb_halt = 0;
  logic        pc_hold, id_ex_bubble, if_id_flush, id_ex_flush, freeze, halted;
  logic [15:0] stall_cnt;
  logic [5:0]  ctl;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] c_none  = 6'b000000;
  localparam logic [5:0] c_haz   = 6'b110000;
  localparam logic [5:0] c_flush = 6'b001100;
  localparam logic [5:0] c_frz   = 6'b000010;
  localparam logic [5:0] c_halt  = 6'b100011;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
    .ex_redirect(ex_redirect), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .wb_halt(wb_halt),
    .pc_hold(pc_hold), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .freeze(freeze), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  // {pc_hold, id_ex_bubble, if_id_flush, id_ex_flush, freeze, halted}
  assign ctl = {pc_hold, id_ex_bubble, if_id_flush, id_ex_flush, freeze, halted};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_wreg = '0; mem_wreg = '0;
    id_rs_vld = 0; id_rt_vld = 0; ex_regwrite = 0; ex_memread = 0;
    mem_regwrite = 0; ex_redirect = 0; dmem_stall = 0; dmem_done = 0; wb_halt = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_use_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 3'd3; id_rs = 3'd3; id_rs_vld = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_use_inputs(); wb_halt = 1; ex_redirect = 1; dmem_stall = 1;
    @(negedge clk);
    checks++;
    if (ctl !== c_none) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, c_none);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0000", stall_cnt);
    end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_none) begin
      errors++; $display("FAIL reset_release_ctl: got %b want %b", ctl, c_none);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== c_haz) begin
      errors++; $display("FAIL load_use_c1: got %b want %b", ctl, c_haz);
    end
    tick();
    ex_memread = 0; ex_regwrite = 0; mem_regwrite = 1; mem_wreg = 3'd3;
    @(negedge clk);
    checks++;
`ifdef FORWARD_EN
    if (ctl !== c_none) begin
      errors++; $display("FAIL load_use_c2: got %b want %b", ctl, c_none);
    end
`else
    if (ctl !== c_haz) begin
      errors++; $display("FAIL load_use_c2: got %b want %b", ctl, c_haz);
    end
`endif
    tick();
    mem_regwrite = 0;
    @(negedge clk);
    checks++;
    if (ctl !== c_none) begin
      errors++; $display("FAIL load_use_c3: got %b want %b", ctl, c_none);
    end
    tick();
    clear_inputs();
    ex_regwrite = 1; ex_wreg = 3'd5; id_rt = 3'd5; id_rt_vld = 1; id_rs = 3'd1; id_rs_vld = 1;
    @(negedge clk);
    checks++;
`ifdef FORWARD_EN
    if (ctl !== c_none) begin
      errors++; $display("FAIL alu_rt_raw: got %b want %b", ctl, c_none);
    end
`else
    if (ctl !== c_haz) begin
      errors++; $display("FAIL alu_rt_raw: got %b want %b", ctl, c_haz);
    end
`endif
    tick();
    ex_memread = 1; id_rt_vld = 0;
    @(negedge clk);
    checks++;
    if (ctl !== c_none) begin
      errors++; $display("FAIL rt_not_valid: got %b want %b", ctl, c_none);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_redirect();
    do_reset();
    load_use_inputs(); ex_redirect = 1;
    @(negedge clk);
    checks++;
    if (ctl !== c_flush) begin
      errors++; $display("FAIL redirect_over_hazard: got %b want %b", ctl, c_flush);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== c_none) begin
      errors++; $display("FAIL redirect_after: got %b want %b", ctl, c_none);
    end
    tick();
  endtask

  task automatic test_mwait();
    logic [5:0] exp_c [1:6];
    exp_c[1] = c_frz; exp_c[2] = c_frz; exp_c[3] = c_frz;
    exp_c[4] = c_none; exp_c[5] = c_flush; exp_c[6] = c_none;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      clear_inputs();
      dmem_stall  = (c <= 4);
      ex_redirect = (c == 2);
      wb_halt     = (c == 3);
      dmem_done   = (c == 4);
      @(negedge clk);
      checks++;
      if (ctl !== exp_c[c]) begin
        errors++; $display("FAIL mwait_c%0d: got %b want %b", c, ctl, exp_c[c]);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL mwait_cnt: got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    load_use_inputs(); wb_halt = 1;
    @(negedge clk);
    checks++;
    if (ctl !== c_frz) begin
      errors++; $display("FAIL halt_entry: got %b want %b", ctl, c_frz);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      ex_redirect = (c == 0); dmem_stall = (c == 1); dmem_done = (c == 2);
      wb_halt = (c == 3);
      @(negedge clk);
      checks++;
      if (ctl !== c_halt) begin
        errors++; $display("FAIL halt_hold_%0d: got %b want %b", c, ctl, c_halt);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL halt_cnt: got %0d want 1", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    dmem_stall = 1;
    tick();
    load_use_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== c_frz) begin
      errors++; $display("FAIL async_pre_mwait: got %b want %b", ctl, c_frz);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== c_none || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL async_assert: got ctl=%b cnt=%0d want ctl=%b cnt=0",
                         ctl, stall_cnt, c_none);
    end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== c_none || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL async_release: got ctl=%b cnt=%0d want ctl=%b cnt=0",
                         ctl, stall_cnt, c_none);
    end
    tick();
    dmem_stall = 1; dmem_done = 1;
    @(negedge clk);
    checks++;
    if (ctl !== c_none) begin
      errors++; $display("FAIL run_done_same_cycle: got %b want %b", ctl, c_none);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    load_use_inputs();
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt);
    end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ffff: got %h want ffff", stall_cnt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF || ctl !== c_haz) begin
      errors++; $display("FAIL sat_hold: got cnt=%h ctl=%b want cnt=ffff ctl=%b",
                         stall_cnt, ctl, c_haz);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mwait();
    test_halt();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
